uart_buffered: RTL and testbench

Buffered, register-mapped UART peripheral on the CPU data bus. It is the successor to the single-byte UART wrapper, with programmable baud divisor, parametrised character width, TX/RX FIFOs, sticky error flags and an interrupt output. Bus accesses complete with a one-cycle ack. Serial lines connect directly to the board COM pins.

---
 rtl/uart_buffered_pkg.sv | 19 +
 rtl/uart_fifo.sv | 38 +++
 rtl/uart_buffered.sv | 176 +++++++++++++++++
 tb/tb_uart_buffered.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_buffered_pkg.sv
// uart_buffered_pkg: register map, status bits, divisor floor and FSM encodings
package uart_buffered_pkg;
  localparam int BUS_W = 32;
  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV = 2'd2;
  localparam logic [1:0] REG_IER = 2'd3;
  localparam int ST_RX_AVAIL = 0;
  localparam int ST_TX_FULL = 1;
  localparam int ST_TX_IDLE = 2;
  localparam int ST_OVERRUN = 3;
  localparam int ST_FRAME_ERR = 4;
  localparam logic [15:0] MIN_DIV = 16'd4;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  function automatic logic [15:0] clamp_div(input logic [15:0] d);
    return d < MIN_DIV ? MIN_DIV : d;
  endfunction
endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous FIFO; a push on a full FIFO succeeds only alongside a pop
module uart_fifo
  import uart_buffered_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic do_push, do_pop;
  assign empty_o = wr_q == rd_q;
  assign full_o = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o = mem_q[rd_q[AW-1:0]];
  // pointer update; the extra MSB distinguishes full from empty
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_q + (AW+1)'(do_push);
      rd_q <= rd_q + (AW+1)'(do_pop);
    end
  // storage write
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
endmodule

// File: rtl/uart_buffered.sv
// uart_buffered: bus-mapped UART with TX/RX FIFOs, sticky errors and interrupt
module uart_buffered
  import uart_buffered_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD = 115200,
  parameter int DATA_BITS = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BUS_W-1:0] bus_addr_i,
  input  logic [BUS_W-1:0] bus_data_i,
  output logic [BUS_W-1:0] bus_data_o,
  input  logic             bus_select_i,
  input  logic             bus_we_i,
  output logic             bus_ack_o,
  output logic             com_TxD,
  input  logic             com_RxD,
  output logic             irq_o
);
  localparam logic [15:0] RST_DIV = 16'(CLK_FREQ / BAUD);
  localparam logic [2:0] LAST = 3'(DATA_BITS - 1);
  logic [15:0] div_q;
  logic [1:0] ier_q, sel;
  logic ovr_q, ferr_q, ack_q, irq_q, txd_q, req, wr, rd, st_clr;
  logic [BUS_W-1:0] rdata_q, rdata;
  logic [4:0] status;
  logic tx_full, tx_empty, tx_pop, tx_load, tx_end, tx_idle;
  logic rx_full, rx_empty, rx_push, rx_pop, rx_end, rx_line, rx_prev;
  logic [DATA_BITS-1:0] tx_dout, rx_dout;
  tx_state_e tx_st_q, tx_st_d;
  rx_state_e rx_st_q, rx_st_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d, rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d, rx_per;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
  logic [2:0] tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d, sync_q;
  logic unused;
  assign unused = ^{bus_addr_i[BUS_W-1:4], bus_addr_i[1:0], bus_data_i[BUS_W-1:16]};
  assign sel = bus_addr_i[3:2];
  assign req = bus_select_i && !ack_q;
  assign wr = req && bus_we_i;
  assign rd = req && !bus_we_i;
  assign rx_pop = rd && sel == REG_DATA;
  assign st_clr = rd && sel == REG_STATUS;
  assign tx_idle = tx_empty && tx_st_q == TX_IDLE;
  assign status = {ferr_q, ovr_q, tx_idle, tx_full, !rx_empty};
  assign rdata = sel == REG_DATA ? (rx_empty ? '0 : BUS_W'(rx_dout)) :
                 sel == REG_STATUS ? BUS_W'(status) :
                 sel == REG_DIV ? BUS_W'(div_q) : BUS_W'(ier_q);
  assign bus_ack_o = ack_q;
  assign bus_data_o = rdata_q;
  assign irq_o = irq_q;
  assign com_TxD = txd_q;
  assign rx_line = sync_q[1];
  assign rx_prev = sync_q[2];
  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push_i(wr && sel == REG_DATA), .pop_i(tx_pop),
    .din_i(bus_data_i[DATA_BITS-1:0]), .dout_o(tx_dout), .full_o(tx_full), .empty_o(tx_empty)
  );
  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push_i(rx_push), .pop_i(rx_pop),
    .din_i(rx_sh_q), .dout_o(rx_dout), .full_o(rx_full), .empty_o(rx_empty)
  );
  // bus handshake, register file, sticky flags and interrupt
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ack_q <= 1'b0;
      rdata_q <= '0;
      div_q <= RST_DIV;
      ier_q <= '0;
      ovr_q <= 1'b0;
      ferr_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      ack_q <= req;
      rdata_q <= rd ? rdata : '0;
      if (wr && sel == REG_DIV) div_q <= clamp_div(bus_data_i[15:0]);
      if (wr && sel == REG_IER) ier_q <= bus_data_i[1:0];
      ovr_q <= (ovr_q && !st_clr) || (rx_push && rx_full && !rx_pop);
      ferr_q <= (ferr_q && !st_clr) || (rx_push && !rx_line);
      irq_q <= (ier_q[0] && !rx_empty) || (ier_q[1] && tx_idle);
    end
  // FSM state registers, line output register and RX synchronizer
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tx_st_q <= TX_IDLE;
      tx_cnt_q <= '0;
      tx_div_q <= RST_DIV;
      tx_sh_q <= '0;
      tx_bit_q <= '0;
      txd_q <= 1'b1;
      rx_st_q <= RX_IDLE;
      rx_cnt_q <= '0;
      rx_div_q <= RST_DIV;
      rx_sh_q <= '0;
      rx_bit_q <= '0;
      sync_q <= '1;
    end else begin
      tx_st_q <= tx_st_d;
      tx_cnt_q <= tx_cnt_d;
      tx_div_q <= tx_div_d;
      tx_sh_q <= tx_sh_d;
      tx_bit_q <= tx_bit_d;
      txd_q <= tx_st_q == TX_START ? 1'b0 : tx_st_q == TX_DATA ? tx_sh_q[0] : 1'b1;
      rx_st_q <= rx_st_d;
      rx_cnt_q <= rx_cnt_d;
      rx_div_q <= rx_div_d;
      rx_sh_q <= rx_sh_d;
      rx_bit_q <= rx_bit_d;
      sync_q <= {sync_q[1:0], com_RxD};
    end
  // TX sequencing; a new frame loads from IDLE or straight out of STOP
  always_comb begin
    tx_end = tx_cnt_q == tx_div_q - 16'd1;
    tx_load = !tx_empty && (tx_st_q == TX_IDLE || (tx_st_q == TX_STOP && tx_end));
    tx_st_d = tx_st_q;
    tx_cnt_d = tx_end ? '0 : tx_cnt_q + 16'd1;
    tx_div_d = tx_div_q;
    tx_sh_d = tx_sh_q;
    tx_bit_d = tx_bit_q;
    tx_pop = 1'b0;
    case (tx_st_q)
      TX_IDLE: tx_cnt_d = '0;
      TX_START: if (tx_end) begin
        tx_bit_d = '0;
        tx_st_d = TX_DATA;
      end
      TX_DATA: if (tx_end) begin
        tx_sh_d = tx_sh_q >> 1;
        tx_bit_d = tx_bit_q + 3'd1;
        tx_st_d = tx_bit_q == LAST ? TX_STOP : TX_DATA;
      end
      default: if (tx_end) tx_st_d = TX_IDLE;
    endcase
    if (tx_load) begin
      tx_pop = 1'b1;
      tx_st_d = TX_START;
      tx_cnt_d = '0;
      tx_div_d = div_q;
      tx_sh_d = tx_dout;
    end
  end
  // RX sequencing: half-period to mid start bit, then one sample per period
  always_comb begin
    rx_per = rx_st_q == RX_START ? {1'b0, rx_div_q[15:1]} : rx_div_q;
    rx_end = rx_cnt_q == rx_per - 16'd1;
    rx_st_d = rx_st_q;
    rx_cnt_d = rx_end ? '0 : rx_cnt_q + 16'd1;
    rx_div_d = rx_div_q;
    rx_sh_d = rx_sh_q;
    rx_bit_d = rx_bit_q;
    rx_push = 1'b0;
    case (rx_st_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev && !rx_line) begin
          rx_st_d = RX_START;
          rx_div_d = div_q;
        end
      end
      RX_START: if (rx_end) begin
        rx_bit_d = '0;
        rx_st_d = rx_line ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_end) begin
        rx_sh_d = {rx_line, rx_sh_q[DATA_BITS-1:1]};
        rx_bit_d = rx_bit_q + 3'd1;
        rx_st_d = rx_bit_q == LAST ? RX_STOP : RX_DATA;
      end
      default: if (rx_end) begin
        rx_push = 1'b1;
        rx_st_d = RX_IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_uart_buffered.sv
// tb_uart_buffered: randomized checks of uart_buffered against a frame/queue model
module tb_uart_buffered;
  localparam int DIV0 = 50000000 / 115200;
  localparam logic [1:0] A_DATA = 2'd0, A_STAT = 2'd1, A_DIV = 2'd2, A_IER = 2'd3;
  logic clk = 0, rst = 1, sel = 0, we = 0, loop_en = 0, rxd_drv = 1;
  logic ack, txd, irq;
  logic [31:0] addr = 0, wdat = 0, rdat, dmy;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  logic [7:0] rq[$];
  logic [7:0] tq[$];
  uart_buffered dut (
    .clk(clk), .rst(rst), .bus_addr_i(addr), .bus_data_i(wdat), .bus_data_o(rdat),
    .bus_select_i(sel), .bus_we_i(we), .bus_ack_o(ack), .com_TxD(txd),
    .com_RxD(loop_en ? txd : rxd_drv), .irq_o(irq)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] st(input bit ra, input bit tf, input bit ti, input bit ov, input bit fe);
    return {27'd0, fe, ov, ti, tf, ra};
  endfunction
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic bus(input logic w, input logic [1:0] r, input logic [31:0] d, output logic [31:0] q);
    @(negedge clk);
    sel = 1; we = w; addr = {28'd0, r, 2'b00}; wdat = d;
    @(posedge clk);
    #1;
    check("ack", ack, 1);
    q = rdat;
    @(negedge clk);
    sel = 0; we = 0;
  endtask
  task automatic rdc(input string tag, input logic [1:0] r, input logic [31:0] exp);
    logic [31:0] q;
    bus(0, r, 0, q);
    check(tag, q, exp);
  endtask
  task automatic send_frame(input logic [7:0] b, input logic stop, input int div);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      rxd_drv = f[i];
      repeat (div) @(negedge clk);
    end
    rxd_drv = 1;
  endtask
  task automatic tx_cap(input int div, output logic [7:0] b, output int t0);
    logic [9:0] f;
    for (int k = 0; k < 2500 && txd; k++) begin
      @(posedge clk);
      #1;
    end
    check("tx_start_seen", txd, 0);
    t0 = cyc;
    repeat (div / 2) @(posedge clk);
    #1;
    f[0] = txd;
    for (int i = 1; i < 10; i++) begin
      repeat (div) @(posedge clk);
      #1;
      f[i] = txd;
    end
    check("tx_frame_start", f[0], 0);
    check("tx_frame_stop", f[9], 1);
    b = f[8:1];
  endtask
  initial begin
    logic [9:0] e;
    logic [7:0] b;
    int div, n;
    logic ovr, low;
    cycles(3);
    check("rst_txd", txd, 1);
    check("rst_ack", ack, 0);
    check("rst_data", rdat, 0);
    check("rst_irq", irq, 0);
    @(negedge clk);
    rst = 0;
    rdc("rst_status", A_STAT, st(0, 0, 1, 0, 0));
    rdc("rst_div", A_DIV, DIV0);
    rdc("rst_ier", A_IER, 0);
    foreach (e[i]) e[i] = 0;
    bus(1, A_DIV, 2, dmy);
    rdc("div_clamp2", A_DIV, 4);
    bus(1, A_DIV, 3, dmy);
    rdc("div_clamp3", A_DIV, 4);
    bus(1, A_DIV, 32'h0001_2345, dmy);
    rdc("div_wide", A_DIV, 32'h2345);
    bus(1, A_DIV, 8, dmy);
    rdc("div8", A_DIV, 8);
    // exact 0x55 waveform: 2-cycle latency, each bit exactly 8 cycles
    b = 8'h55;
    e = {1'b1, b, 1'b0};
    bus(1, A_DATA, {24'd0, b}, dmy);
    cycles(1);
    check("ack_once", ack, 0);
    check("tx_lat1", txd, 1);
    cycles(1);
    for (int i = 0; i < 10; i++) begin
      check("tx55_bit_first", txd, e[i]);
      cycles(7);
      check("tx55_bit_last", txd, e[i]);
      cycles(1);
    end
    check("tx55_after", txd, 1);
    // held select: ack pulses every other cycle
    @(negedge clk);
    sel = 1; we = 0; addr = {28'd0, A_STAT, 2'b00};
    for (int i = 0; i < 4; i++) begin
      cycles(1);
      check("ack_hold", ack, (i % 2 == 0) ? 1 : 0);
      if (i % 2 == 0) check("ack_hold_data", rdat, st(0, 0, 1, 0, 0));
    end
    @(negedge clk);
    sel = 0;
    bus(1, A_IER, 2, dmy);
    cycles(2);
    check("irq_tx_idle", irq, 1);
    bus(1, A_IER, 0, dmy);
    cycles(2);
    check("irq_off", irq, 0);
    // full TX FIFO while a slow frame is in flight; divisor change latched per frame
    bus(1, A_DIV, 200, dmy);
    fork
      begin
        int t0, tp;
        logic [7:0] got;
        tp = 0;
        for (int f = 0; f < 17; f++) begin
          tx_cap(f == 0 ? 200 : 8, got, t0);
          if (f > 0) check("tx_gap", t0 - tp, f == 1 ? 2000 : 80);
          check("tx_byte", got, tq.size() > 0 ? tq.pop_front() : 8'hxx);
          tp = t0;
        end
      end
      begin
        logic [7:0] d;
        d = 8'($urandom);
        tq.push_back(d);
        bus(1, A_DATA, {24'd0, d}, dmy);
        cycles(4);
        for (int i = 0; i < 17; i++) begin
          d = 8'($urandom);
          if (i < 16) tq.push_back(d);
          bus(1, A_DATA, {24'd0, d}, dmy);
        end
        rdc("tx_full_status", A_STAT, st(0, 1, 0, 0, 0));
        bus(1, A_DIV, 8, dmy);
      end
    join
    low = 0;
    for (int i = 0; i < 200; i++) begin
      cycles(1);
      if (!txd) low = 1;
    end
    check("tx_no_extra", low, 0);
    rdc("tx_drained", A_STAT, st(0, 0, 1, 0, 0));
    // loopback with random divisors and bytes
    loop_en = 1;
    bus(1, A_IER, 1, dmy);
    for (int it = 0; it < 6; it++) begin
      div = it == 0 ? 8 : $urandom_range(4, 24);
      n = it == 0 ? 1 : $urandom_range(1, 3);
      bus(1, A_DIV, div, dmy);
      for (int j = 0; j < n; j++) begin
        b = it == 0 ? 8'hA3 : 8'($urandom);
        rq.push_back(b);
        bus(1, A_DATA, {24'd0, b}, dmy);
      end
      cycles((n + 1) * 10 * div + 20);
      check("irq_rx", irq, 1);
      rdc("lb_status", A_STAT, st(1, 0, 1, 0, 0));
      while (rq.size() > 0) rdc("lb_data", A_DATA, {24'd0, rq.pop_front()});
      cycles(1);
      check("irq_rx_clear", irq, 0);
      rdc("lb_empty_read", A_DATA, 0);
    end
    bus(1, A_IER, 0, dmy);
    loop_en = 0;
    bus(1, A_DIV, 8, dmy);
    // overrun: 17 injected frames into a 16-deep FIFO
    ovr = 0;
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom);
      if (rq.size() < 16) rq.push_back(b); else ovr = 1;
      send_frame(b, 1, 8);
    end
    cycles(20);
    rdc("ovr_status", A_STAT, st(1, 0, 1, ovr, 0));
    rdc("ovr_cleared", A_STAT, st(1, 0, 1, 0, 0));
    while (rq.size() > 0) rdc("ovr_data", A_DATA, {24'd0, rq.pop_front()});
    rdc("ovr_empty", A_STAT, st(0, 0, 1, 0, 0));
    // framing error keeps the character
    b = 8'($urandom);
    send_frame(b, 0, 8);
    cycles(10);
    rdc("ferr_status", A_STAT, st(1, 0, 1, 0, 1));
    rdc("ferr_data", A_DATA, {24'd0, b});
    rdc("ferr_cleared", A_STAT, st(0, 0, 1, 0, 0));
    // one-cycle glitch is rejected
    @(negedge clk);
    rxd_drv = 0;
    @(negedge clk);
    rxd_drv = 1;
    cycles(40);
    rdc("glitch_status", A_STAT, st(0, 0, 1, 0, 0));
    // asynchronous reset in the middle of a frame
    bus(1, A_IER, 3, dmy);
    bus(1, A_DATA, 0, dmy);
    cycles(20);
    check("txd_midframe", txd, 0);
    #2 rst = 1;
    #1;
    check("txd_async_rst", txd, 1);
    check("ack_async_rst", ack, 0);
    check("irq_async_rst", irq, 0);
    @(negedge clk);
    rst = 0;
    rdc("post_rst_status", A_STAT, st(0, 0, 1, 0, 0));
    rdc("post_rst_div", A_DIV, DIV0);
    rdc("post_rst_ier", A_IER, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
